// File: rtl/motor_dir_ctrl.sv
// H-bridge direction controller with APB registers, a dead-time
// sequencer that prevents shoot-through, and a CTRL-write watchdog.
module motor_dir_ctrl #(
    parameter logic [15:0] BASE_ADDR           = 16'h0000,
    parameter logic [15:0] DEFAULT_DEADTIME_CC = 16'd100,
    parameter logic [31:0] DEFAULT_WDT_CC      = 32'd0
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        PWM_EN,
    output logic        DIR_A,
    output logic        DIR_B
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_DEAD  = 2'd1,
        S_RUN   = 2'd2,
        S_BRAKE = 2'd3
    } state_t;

    localparam logic [15:0] A_CTRL = BASE_ADDR;
    localparam logic [15:0] A_DT   = BASE_ADDR + 16'd4;
    localparam logic [15:0] A_WDT  = BASE_ADDR + 16'd8;
    localparam logic [15:0] A_STAT = BASE_ADDR + 16'd12;

    logic [2:0]  r_ctrl;
    logic [15:0] r_deadtime;
    logic [31:0] r_wdt;
    logic [31:0] r_wdt_cnt;
    logic        r_wdt_trip;
    state_t      r_state;
    logic [15:0] r_dead_cnt;
    logic        r_applied_dir;
    logic [31:0] r_prdata;
    logic        r_pwm_en;
    logic        r_dir_a;
    logic        r_dir_b;

    logic [15:0] w_addr;
    logic        w_wr;
    logic        w_ctrl_wr;
    logic        w_dt_wr;
    logic        w_wdt_wr;
    logic [31:0] w_rdata;
    logic        w_en;
    logic        w_dir;
    logic        w_brk;
    logic        w_tgt_off;
    logic [15:0] w_dead_lim;
    logic        w_dead_done;
    state_t      w_state_nxt;
    logic [15:0] w_dead_cnt_nxt;
    logic        w_applied_dir_nxt;
    logic        w_pwm_en_nxt;
    logic        w_dir_a_nxt;
    logic        w_dir_b_nxt;
    logic        w_unused;

    assign w_addr    = PADDR[15:0];
    assign w_unused  = ^PADDR[31:16];
    assign w_wr      = PSEL & PENABLE & PWRITE;
    assign w_ctrl_wr = w_wr && (w_addr == A_CTRL);
    assign w_dt_wr   = w_wr && (w_addr == A_DT);
    assign w_wdt_wr  = w_wr && (w_addr == A_WDT);

    assign w_en      = r_ctrl[0];
    assign w_dir     = r_ctrl[1];
    assign w_brk     = r_ctrl[2];
    assign w_tgt_off = !w_en || r_wdt_trip;

    assign w_dead_lim  = (r_deadtime == 16'd0) ? 16'd1 : r_deadtime;
    assign w_dead_done = ({1'b0, r_dead_cnt} + 17'd1) >= {1'b0, w_dead_lim};

    assign PREADY  = 1'b1;
    assign PSLVERR = 1'b0;
    assign PRDATA  = r_prdata;
    assign PWM_EN  = r_pwm_en;
    assign DIR_A   = r_dir_a;
    assign DIR_B   = r_dir_b;

    // Configuration registers written from the APB bus
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_ctrl     <= 3'd0;
            r_deadtime <= DEFAULT_DEADTIME_CC;
            r_wdt      <= DEFAULT_WDT_CC;
        end else begin
            if (w_ctrl_wr) r_ctrl <= PWDATA[2:0];
            if (w_dt_wr)   r_deadtime <= PWDATA[15:0];
            if (w_wdt_wr)  r_wdt <= PWDATA;
        end
    end

    // Watchdog: CTRL writes kick it and take priority over a trip
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_wdt_cnt  <= 32'd0;
            r_wdt_trip <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_wdt_cnt  <= 32'd0;
            r_wdt_trip <= 1'b0;
        end else begin
            if (!w_en) begin
                r_wdt_cnt <= 32'd0;
            end else if (r_wdt_cnt != 32'hFFFF_FFFF) begin
                r_wdt_cnt <= r_wdt_cnt + 32'd1;
            end
            if ((r_wdt != 32'd0) && (r_wdt_cnt == r_wdt)) begin
                r_wdt_trip <= 1'b1;
            end
        end
    end

    // Read mux, addressed register zero-extended
    always_comb begin
        w_rdata = 32'd0;
        if (w_addr == A_CTRL) begin
            w_rdata = {29'd0, r_ctrl};
        end else if (w_addr == A_DT) begin
            w_rdata = {16'd0, r_deadtime};
        end else if (w_addr == A_WDT) begin
            w_rdata = r_wdt;
        end else if (w_addr == A_STAT) begin
            w_rdata = {29'd0, r_wdt_trip, r_state};
        end
    end

    // Registered read data
    always_ff @(posedge PCLK) begin
        if (!PRESERN) r_prdata <= 32'd0;
        else          r_prdata <= w_rdata;
    end

    // Next-state and next-output logic of the bridge sequencer
    always_comb begin
        w_state_nxt       = r_state;
        w_dead_cnt_nxt    = r_dead_cnt;
        w_applied_dir_nxt = r_applied_dir;
        unique case (r_state)
            S_OFF: begin
                if (!w_tgt_off) begin
                    w_state_nxt    = S_DEAD;
                    w_dead_cnt_nxt = 16'd0;
                end
            end
            S_DEAD: begin
                if (w_tgt_off) begin
                    w_state_nxt = S_OFF;
                end else if (w_dead_done) begin
                    if (w_brk) begin
                        w_state_nxt = S_BRAKE;
                    end else begin
                        w_state_nxt       = S_RUN;
                        w_applied_dir_nxt = w_dir;
                    end
                end else begin
                    w_dead_cnt_nxt = r_dead_cnt + 16'd1;
                end
            end
            S_RUN: begin
                if (w_tgt_off) begin
                    w_state_nxt = S_OFF;
                end else if (w_brk || (w_dir != r_applied_dir)) begin
                    w_state_nxt    = S_DEAD;
                    w_dead_cnt_nxt = 16'd0;
                end
            end
            S_BRAKE: begin
                if (w_tgt_off) begin
                    w_state_nxt = S_OFF;
                end else if (!w_brk) begin
                    w_state_nxt    = S_DEAD;
                    w_dead_cnt_nxt = 16'd0;
                end
            end
            default: begin
                w_state_nxt = S_OFF;
            end
        endcase

        w_pwm_en_nxt = 1'b0;
        w_dir_a_nxt  = 1'b0;
        w_dir_b_nxt  = 1'b0;
        unique case (w_state_nxt)
            S_RUN: begin
                w_pwm_en_nxt = 1'b1;
                w_dir_a_nxt  = w_applied_dir_nxt;
                w_dir_b_nxt  = !w_applied_dir_nxt;
            end
            S_BRAKE: begin
                w_dir_a_nxt = 1'b1;
                w_dir_b_nxt = 1'b1;
            end
            default: begin
                w_pwm_en_nxt = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered bridge outputs
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            r_state       <= S_OFF;
            r_dead_cnt    <= 16'd0;
            r_applied_dir <= 1'b0;
            r_pwm_en      <= 1'b0;
            r_dir_a       <= 1'b0;
            r_dir_b       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dead_cnt    <= w_dead_cnt_nxt;
            r_applied_dir <= w_applied_dir_nxt;
            r_pwm_en      <= w_pwm_en_nxt;
            r_dir_a       <= w_dir_a_nxt;
            r_dir_b       <= w_dir_b_nxt;
        end
    end

endmodule

// File: tb/tb_motor_dir_ctrl.sv
// Directed bench for motor_dir_ctrl: registers, dead-time
// sequencing, watchdog and reset abort.
module tb_motor_dir_ctrl;

    localparam logic [15:0] B = 16'h0100;

    logic        PCLK;
    logic        PRESERN;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        PWM_EN;
    logic        DIR_A;
    logic        DIR_B;

    int checks;
    int errors;

    motor_dir_ctrl #(
        .BASE_ADDR(B),
        .DEFAULT_DEADTIME_CC(16'd100),
        .DEFAULT_WDT_CC(32'd0)
    ) dut (
        .PCLK(PCLK),
        .PRESERN(PRESERN),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PADDR(PADDR),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR),
        .PWM_EN(PWM_EN),
        .DIR_A(DIR_A),
        .DIR_B(DIR_B)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Returns just after the edge that performs the write
    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = {16'h5A5A, a};
        PWDATA  = d;
        step();
        PENABLE = 1'b1;
        step();
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = {16'hA5A5, a};
        step();
        d    = PRDATA;
        PSEL = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        PRESERN = 1'b0;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
        repeat (3) step();
        PRESERN = 1'b1;
        checks++;
        if ({PWM_EN, DIR_A, DIR_B, PREADY, PSLVERR} !== 5'b00010) begin
            errors++;
            $display("FAIL reset_out got=%b exp=00010",
                     {PWM_EN, DIR_A, DIR_B, PREADY, PSLVERR});
        end
        apb_read(B + 16'd4, d);
        checks++;
        if (d !== 32'd100) begin
            errors++;
            $display("FAIL reset_dt got=%0d exp=100", d);
        end
        apb_read(B + 16'd12, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_status got=%0d exp=0", d);
        end
        apb_read(B + 16'd8, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_wdt got=%0d exp=0", d);
        end
    endtask

    task automatic test_decode();
        logic [31:0] d;
        apb_write(B + 16'd16, 32'h0000_0007);
        PSEL = 1'b0; PENABLE = 1'b1; PWRITE = 1'b1;
        PADDR = {16'h0, B + 16'd4}; PWDATA = 32'd55;
        step();
        PENABLE = 1'b0; PWRITE = 1'b0;
        apb_read(B + 16'd4, d);
        checks++;
        if (d !== 32'd100) begin
            errors++;
            $display("FAIL decode_dt got=%0d exp=100", d);
        end
        apb_write(B, 32'hFFFF_FFF8);
        repeat (2) step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
            errors++;
            $display("FAIL decode_ctrl_out got=%b exp=000",
                     {PWM_EN, DIR_A, DIR_B});
        end
        apb_read(B, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL decode_ctrl got=%0d exp=0", d);
        end
        apb_read(B + 16'd20, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL decode_unmapped got=%0h exp=0", d);
        end
        apb_write(B + 16'd4, 32'hFFFF_0010);
        apb_read(B + 16'd4, d);
        checks++;
        if (d !== 32'h10) begin
            errors++;
            $display("FAIL decode_dt_mask got=%0h exp=10", d);
        end
    endtask

    task automatic test_run_entry();
        apb_write(B + 16'd4, 32'd10);
        apb_write(B, 32'd1);
        PADDR = {16'h0, B + 16'd12};
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
                errors++;
                $display("FAIL run_entry_dead i=%0d got=%b exp=000",
                         i, {PWM_EN, DIR_A, DIR_B});
            end
            if (i == 5) begin
                checks++;
                if (PRDATA !== 32'd1) begin
                    errors++;
                    $display("FAIL run_entry_status got=%0d exp=1", PRDATA);
                end
            end
        end
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b101) begin
            errors++;
            $display("FAIL run_entry_run got=%b exp=101",
                     {PWM_EN, DIR_A, DIR_B});
        end
        step();
        checks++;
        if (PRDATA !== 32'd2) begin
            errors++;
            $display("FAIL run_status got=%0d exp=2", PRDATA);
        end
    endtask

    task automatic test_dir_change();
        apb_write(B, 32'd3);
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b101) begin
            errors++;
            $display("FAIL dir_hold got=%b exp=101", {PWM_EN, DIR_A, DIR_B});
        end
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
                errors++;
                $display("FAIL dir_dead i=%0d got=%b exp=000",
                         i, {PWM_EN, DIR_A, DIR_B});
            end
        end
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b110) begin
            errors++;
            $display("FAIL dir_run got=%b exp=110", {PWM_EN, DIR_A, DIR_B});
        end
    endtask

    task automatic test_brake();
        logic [31:0] d;
        apb_write(B, 32'd7);
        repeat (10) step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
            errors++;
            $display("FAIL brake_dead got=%b exp=000", {PWM_EN, DIR_A, DIR_B});
        end
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b011) begin
            errors++;
            $display("FAIL brake_on got=%b exp=011", {PWM_EN, DIR_A, DIR_B});
        end
        apb_read(B + 16'd12, d);
        checks++;
        if (d !== 32'd3) begin
            errors++;
            $display("FAIL brake_status got=%0d exp=3", d);
        end
    endtask

    task automatic test_no_restart();
        apb_write(B, 32'd3);
        repeat (3) step();
        apb_write(B, 32'd1);
        repeat (5) step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
            errors++;
            $display("FAIL norestart_dead got=%b exp=000",
                     {PWM_EN, DIR_A, DIR_B});
        end
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b101) begin
            errors++;
            $display("FAIL norestart_run got=%b exp=101",
                     {PWM_EN, DIR_A, DIR_B});
        end
    endtask

    task automatic test_off();
        apb_write(B, 32'd0);
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
            errors++;
            $display("FAIL off_out got=%b exp=000", {PWM_EN, DIR_A, DIR_B});
        end
        PADDR = {16'h0, B + 16'd12};
        step();
        checks++;
        if (PRDATA !== 32'd0) begin
            errors++;
            $display("FAIL off_status got=%0d exp=0", PRDATA);
        end
    endtask

    task automatic test_dt_shrink();
        apb_write(B, 32'd1);
        repeat (6) step();
        apb_write(B + 16'd4, 32'd3);
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
            errors++;
            $display("FAIL shrink_dead got=%b exp=000", {PWM_EN, DIR_A, DIR_B});
        end
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b101) begin
            errors++;
            $display("FAIL shrink_run got=%b exp=101", {PWM_EN, DIR_A, DIR_B});
        end
        apb_write(B, 32'd0);
        step();
    endtask

    task automatic test_dt_zero();
        apb_write(B + 16'd4, 32'd0);
        apb_write(B, 32'd1);
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
            errors++;
            $display("FAIL dt0_dead got=%b exp=000", {PWM_EN, DIR_A, DIR_B});
        end
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b101) begin
            errors++;
            $display("FAIL dt0_run got=%b exp=101", {PWM_EN, DIR_A, DIR_B});
        end
        apb_write(B, 32'd0);
        apb_write(B + 16'd4, 32'd10);
        step();
    endtask

    task automatic test_watchdog();
        apb_write(B + 16'd8, 32'd50);
        apb_write(B, 32'd1);
        repeat (11) step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b101) begin
            errors++;
            $display("FAIL wdt_run got=%b exp=101", {PWM_EN, DIR_A, DIR_B});
        end
        repeat (40) step();
        checks++;
        if (PWM_EN !== 1'b1) begin
            errors++;
            $display("FAIL wdt_pre_trip got=%b exp=1", PWM_EN);
        end
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
            errors++;
            $display("FAIL wdt_off got=%b exp=000", {PWM_EN, DIR_A, DIR_B});
        end
        PADDR = {16'h0, B + 16'd12};
        step();
        checks++;
        if (PRDATA !== 32'd4) begin
            errors++;
            $display("FAIL wdt_status got=%0d exp=4", PRDATA);
        end
        apb_write(B, 32'd1);
        PADDR = {16'h0, B + 16'd12};
        step();
        checks++;
        if (PRDATA !== 32'd0) begin
            errors++;
            $display("FAIL wdt_clear got=%0d exp=0", PRDATA);
        end
        repeat (10) step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b101) begin
            errors++;
            $display("FAIL wdt_rerun got=%b exp=101", {PWM_EN, DIR_A, DIR_B});
        end
        apb_write(B, 32'd0);
        step();
    endtask

    task automatic test_wdt_race();
        apb_write(B, 32'd1);
        repeat (49) step();
        apb_write(B, 32'd1);
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b101) begin
            errors++;
            $display("FAIL race_run got=%b exp=101", {PWM_EN, DIR_A, DIR_B});
        end
        PADDR = {16'h0, B + 16'd12};
        step();
        checks++;
        if (PRDATA !== 32'd2) begin
            errors++;
            $display("FAIL race_status got=%0d exp=2", PRDATA);
        end
        apb_write(B, 32'd0);
        step();
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        apb_write(B, 32'd1);
        repeat (4) step();
        PADDR   = {16'h0, B + 16'd4};
        PRESERN = 1'b0;
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b000 || PRDATA !== 32'd0) begin
            errors++;
            $display("FAIL abort_dead got=%b/%0d exp=000/0",
                     {PWM_EN, DIR_A, DIR_B}, PRDATA);
        end
        PRESERN = 1'b1;
        apb_read(B + 16'd4, d);
        checks++;
        if (d !== 32'd100) begin
            errors++;
            $display("FAIL abort_dt got=%0d exp=100", d);
        end
        apb_read(B + 16'd8, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL abort_wdt got=%0d exp=0", d);
        end
        apb_read(B, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL abort_ctrl got=%0d exp=0", d);
        end
        apb_write(B + 16'd4, 32'd2);
        apb_write(B, 32'd5);
        repeat (4) step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b011) begin
            errors++;
            $display("FAIL abort_brake_on got=%b exp=011",
                     {PWM_EN, DIR_A, DIR_B});
        end
        PRESERN = 1'b0;
        step();
        checks++;
        if ({PWM_EN, DIR_A, DIR_B} !== 3'b000) begin
            errors++;
            $display("FAIL abort_brake got=%b exp=000", {PWM_EN, DIR_A, DIR_B});
        end
        PRESERN = 1'b1;
        apb_read(B + 16'd12, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL abort_status got=%0d exp=0", d);
        end
        apb_read(B + 16'd4, d);
        checks++;
        if (d !== 32'd100) begin
            errors++;
            $display("FAIL abort_dt2 got=%0d exp=100", d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_decode();
        test_run_entry();
        test_dir_change();
        test_brake();
        test_no_restart();
        test_off();
        test_dt_shrink();
        test_dt_zero();
        test_watchdog();
        test_wdt_race();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
